// File: rtl/tile_loader_if.sv
// Bundle of request, status, AXI read-channel and operand-SRAM write signals
// exchanged between the tile loader (master modport) and its environment.
interface tile_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int BUF_AW = 8
);
  logic              req_valid;
  logic [2:0]        req_sel;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic              busy;
  logic              finish;
  logic              err;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic              r_valid;
  logic              r_ready;
  logic [WIDTH-1:0]  r_data;
  logic              r_last;
  logic [1:0]        r_resp;
  logic [2:0]        buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [WIDTH-1:0]  buf_wdata;

  // AR and R transfer on a rising clk edge where valid && ready are both high;
  // a source holds valid and its payload stable until that edge.
  modport master (
    input  req_valid, req_sel, base_a, base_b, base_c,
    input  ar_ready, r_valid, r_data, r_last, r_resp,
    output busy, finish, err, ar_valid, ar_addr, ar_len, r_ready,
    output buf_we, buf_addr, buf_wdata
  );

  modport slave (
    output req_valid, req_sel, base_a, base_b, base_c,
    output ar_ready, r_valid, r_data, r_last, r_resp,
    input  busy, finish, err, ar_valid, ar_addr, ar_len, r_ready,
    input  buf_we, buf_addr, buf_wdata
  );
endinterface

// File: rtl/tile_loader.sv
// Operand tile loader: fetches an A, B or C tile over AXI read bursts and
// writes each returned word into the selected operand SRAM.
module tile_loader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int A_WORDS   = 128,
  parameter int B_WORDS   = 256,
  parameter int C_WORDS   = 128,
  parameter int BUF_AW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  tile_loader_if.master  bus,
  output logic [1:0]     dbg_state_o
);
  localparam int CW = BUF_AW + 1;
  localparam logic [CW-1:0]     A_TOT   = CW'(A_WORDS);
  localparam logic [CW-1:0]     B_TOT   = CW'(B_WORDS);
  localparam logic [CW-1:0]     C_TOT   = CW'(C_WORDS);
  localparam logic [CW-1:0]     BL_CW   = CW'(BURST_LEN);
  localparam logic [7:0]        BL_M1   = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(WIDTH / 8);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [CW-1:0]     total_q, total_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        len_q, len_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic [2:0]        we_q, we_d;
  logic [BUF_AW-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;

  logic [CW-1:0]     remain;
  logic [7:0]        ar_len_c;
  logic [ADDR_W-1:0] req_base;
  logic [CW-1:0]     req_total;
  logic [ADDR_W-1:0] step;
  logic              burst_end;

  assign remain   = total_q - word_cnt_q;
  assign ar_len_c = (remain > BL_CW) ? BL_M1 : 8'(remain - CW'(1));
  assign step     = (ADDR_W'(len_q) + ADDR_W'(1)) * BYTES_A;

  always_comb begin
    req_base  = '0;
    req_total = '0;
    case (bus.req_sel)
      3'b001:  begin req_base = bus.base_c; req_total = C_TOT; end
      3'b010:  begin req_base = bus.base_a; req_total = A_TOT; end
      3'b100:  begin req_base = bus.base_b; req_total = B_TOT; end
      default: begin req_base = '0;         req_total = '0;    end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      total_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      total_q    <= total_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      last_q     <= last_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    total_d    = total_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    last_d     = last_q;
    we_d       = '0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    burst_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if ($onehot(bus.req_sel)) begin
            sel_d      = bus.req_sel;
            total_d    = req_total;
            addr_d     = req_base;
            word_cnt_d = '0;
            err_d      = 1'b0;
            last_d     = 1'b0;
            state_d    = ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ADDR: begin
        if (bus.ar_ready) begin
          len_d      = ar_len_c;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        // last_q marks the one-cycle wait for the final SRAM write to land
        if (last_q) begin
          state_d = DONE;
        end else if (bus.r_valid) begin
          burst_end  = (beat_cnt_q == len_q);
          we_d       = sel_q;
          waddr_d    = word_cnt_q[BUF_AW-1:0];
          wdata_d    = bus.r_data;
          word_cnt_d = word_cnt_q + CW'(1);
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ((bus.r_last != burst_end) || (bus.r_resp != 2'b00)) err_d = 1'b1;
          if (burst_end) begin
            addr_d = addr_q + step;
            if ((word_cnt_q + CW'(1)) < total_q) state_d = ADDR;
            else                                 last_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.finish    = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.ar_valid  = (state_q == ADDR);
  assign bus.ar_addr   = (state_q == ADDR) ? addr_q : '0;
  assign bus.ar_len    = (state_q == ADDR) ? ar_len_c : '0;
  assign bus.r_ready   = (state_q == DATA) && !last_q;
  assign bus.buf_we    = we_q;
  assign bus.buf_addr  = waddr_q;
  assign bus.buf_wdata = wdata_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_tile_loader.sv
// Bench for tile_loader: an AXI read responder backed by a hashed memory,
// a write scoreboard and one task per scenario.
module tb_tile_loader;
  localparam int SBW = 3 + 8 + 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tile_loader_if #(.WIDTH(32), .ADDR_W(32), .BUF_AW(8)) bus ();
  tile_loader_if #(.WIDTH(32), .ADDR_W(32), .BUF_AW(8)) bus_c ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_c;

  tile_loader u_dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state));
  tile_loader #(.C_WORDS(20)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c), .dbg_state_o(dbg_state_c));

  logic        tgt = 1'b0;
  logic        req_valid_drv = 1'b0;
  logic [2:0]  req_sel_drv = 3'b000;
  logic [31:0] base_a_drv = '0, base_b_drv = '0, base_c_drv = '0;
  logic        ar_ready_drv = 1'b0, r_valid_drv = 1'b0, r_last_drv = 1'b0;
  logic [31:0] r_data_drv = '0;
  logic [1:0]  r_resp_drv = '0;

  assign bus.req_valid   = !tgt && req_valid_drv;
  assign bus_c.req_valid = tgt && req_valid_drv;
  assign bus.req_sel     = req_sel_drv;
  assign bus_c.req_sel   = req_sel_drv;
  assign bus.base_a = base_a_drv;  assign bus_c.base_a = base_a_drv;
  assign bus.base_b = base_b_drv;  assign bus_c.base_b = base_b_drv;
  assign bus.base_c = base_c_drv;  assign bus_c.base_c = base_c_drv;
  assign bus.ar_ready   = !tgt && ar_ready_drv;
  assign bus_c.ar_ready = tgt && ar_ready_drv;
  assign bus.r_valid    = !tgt && r_valid_drv;
  assign bus_c.r_valid  = tgt && r_valid_drv;
  assign bus.r_data = r_data_drv;  assign bus_c.r_data = r_data_drv;
  assign bus.r_last = r_last_drv;  assign bus_c.r_last = r_last_drv;
  assign bus.r_resp = r_resp_drv;  assign bus_c.r_resp = r_resp_drv;

  logic        m_ar_valid, m_r_ready, m_finish, m_err, m_busy;
  logic [31:0] m_ar_addr, m_buf_wdata;
  logic [7:0]  m_ar_len, m_buf_addr;
  logic [2:0]  m_buf_we;
  assign m_ar_valid  = tgt ? bus_c.ar_valid  : bus.ar_valid;
  assign m_ar_addr   = tgt ? bus_c.ar_addr   : bus.ar_addr;
  assign m_ar_len    = tgt ? bus_c.ar_len    : bus.ar_len;
  assign m_r_ready   = tgt ? bus_c.r_ready   : bus.r_ready;
  assign m_finish    = tgt ? bus_c.finish    : bus.finish;
  assign m_err       = tgt ? bus_c.err       : bus.err;
  assign m_busy      = tgt ? bus_c.busy      : bus.busy;
  assign m_buf_we    = tgt ? bus_c.buf_we    : bus.buf_we;
  assign m_buf_addr  = tgt ? bus_c.buf_addr  : bus.buf_addr;
  assign m_buf_wdata = tgt ? bus_c.buf_wdata : bus.buf_wdata;

  int tests_run = 0;
  int tests_failed = 0;

  // responder configuration and observation
  int          ar_delay = 0;
  bit          gaps = 1'b0;
  int          inj_resp_beat = -1, inj_last_beat = -1;
  int          global_beat = 0;
  int          ar_unstable = 0;
  int          ar_wait = 0, beat_idx = 0;
  bit          hs_now = 1'b0, hs_prev = 1'b0, r_pend = 1'b0;
  logic [31:0] ar_first_addr = '0;
  logic [7:0]  ar_first_len = '0;
  logic [31:0] bq_addr[$];
  logic [7:0]  bq_len[$];
  logic [31:0] ar_log_addr[$];
  logic [7:0]  ar_log_len[$];

  // scoreboard
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] got_q[$];
  bit             err_at_wr[$];
  int lat_err, fin_cnt, fin_cyc, last_wr_cyc;
  bit timed_out, busy_after, err_at_fin, err_after;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // AXI read slave: decides at each negedge what the next posedge transfers
  initial begin
    logic [31:0] cur;
    forever begin
      @(negedge clk);
      hs_prev = hs_now;
      hs_now = 1'b0;
      if (!rst) begin
        bq_addr.delete(); bq_len.delete();
        ar_ready_drv = 1'b0; r_valid_drv = 1'b0; r_last_drv = 1'b0; r_resp_drv = 2'b00;
        ar_wait = 0; beat_idx = 0; r_pend = 1'b0;
      end else begin
        ar_ready_drv = 1'b0;
        if (m_ar_valid) begin
          if (ar_wait == 0) begin
            ar_first_addr = m_ar_addr; ar_first_len = m_ar_len;
          end else if (m_ar_addr !== ar_first_addr || m_ar_len !== ar_first_len) begin
            ar_unstable++;
          end
          if (ar_wait >= ar_delay) begin
            ar_ready_drv = 1'b1;
            ar_log_addr.push_back(m_ar_addr); ar_log_len.push_back(m_ar_len);
            bq_addr.push_back(m_ar_addr);     bq_len.push_back(m_ar_len);
            ar_wait = 0;
          end else begin
            ar_wait++;
          end
        end
        r_valid_drv = 1'b0; r_last_drv = 1'b0; r_resp_drv = 2'b00;
        if (bq_len.size() != 0 && (r_pend || !gaps || $urandom_range(0, 3) != 0)) begin
          cur = bq_addr[0] + 32'(beat_idx) * 4;
          r_valid_drv = 1'b1;
          r_data_drv  = mem_word(cur);
          r_last_drv  = (beat_idx == int'(bq_len[0])) || (global_beat == inj_last_beat);
          r_resp_drv  = (global_beat == inj_resp_beat) ? 2'd2 : 2'd0;
          if (m_r_ready) begin
            hs_now = 1'b1;
            global_beat++;
            if (beat_idx == int'(bq_len[0])) begin
              void'(bq_addr.pop_front()); void'(bq_len.pop_front()); beat_idx = 0;
            end else begin
              beat_idx++;
            end
          end
        end
        r_pend = r_valid_drv && !hs_now;
      end
    end
  end

  task automatic push_exp(input logic [2:0] sel, input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({sel, 8'(i), mem_word(base + 32'(i) * 4)});
  endtask

  task automatic prep(input int delay, input bit g);
    ar_log_addr.delete(); ar_log_len.delete();
    ar_delay = delay; gaps = g; global_beat = 0; ar_unstable = 0;
    inj_resp_beat = -1; inj_last_beat = -1;
  endtask

  task automatic send_req(input logic [2:0] sel);
    req_sel_drv = sel; req_valid_drv = 1'b1;
    @(negedge clk); #1;
    req_valid_drv = 1'b0;
  endtask

  // records SRAM writes and finish timing until finish or budget
  task automatic collect(input int budget);
    int cyc;
    bit done;
    cyc = 0; done = 1'b0;
    lat_err = 0; fin_cnt = 0; fin_cyc = -1; last_wr_cyc = -1;
    got_q.delete(); err_at_wr.delete();
    while (!done && cyc < budget) begin
      if ((m_buf_we != 3'b000) !== hs_prev) lat_err++;
      if (m_buf_we != 3'b000) begin
        got_q.push_back({m_buf_we, m_buf_addr, m_buf_wdata});
        err_at_wr.push_back(m_err);
        last_wr_cyc = cyc;
      end
      if (m_finish) begin fin_cnt++; fin_cyc = cyc; err_at_fin = m_err; done = 1'b1; end
      @(negedge clk); #1;
      cyc++;
    end
    timed_out = !done;
    if (m_finish) fin_cnt++;
    busy_after = m_busy;
    err_after = m_err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.finish, bus.err, bus.ar_valid, bus.r_ready} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b, expected 00000",
        {bus.busy, bus.finish, bus.err, bus.ar_valid, bus.r_ready});
    end
    tests_run++;
    if (bus.ar_addr !== 32'h0 || bus.ar_len !== 8'h0) begin
      tests_failed++; $display("FAIL reset_ar: got addr %h len %h, expected 0", bus.ar_addr, bus.ar_len);
    end
    tests_run++;
    if (bus.buf_we !== 3'b0 || bus.buf_addr !== 8'h0 || bus.buf_wdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_buf: got we %b addr %h data %h, expected 0",
        bus.buf_we, bus.buf_addr, bus.buf_wdata);
    end
    tests_run++;
    if (dbg_state !== 2'd0 || dbg_state_c !== 2'd0 || bus_c.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state: got %0d/%0d, expected 0/0", dbg_state, dbg_state_c);
    end
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_load_a();
    logic [SBW-1:0] e, g;
    prep(0, 1'b0);
    base_a_drv = 32'h1000;
    push_exp(3'b010, 32'h1000, 128);
    send_req(3'b010);
    tests_run++;
    if (m_ar_valid !== 1'b1 || m_busy !== 1'b1) begin
      tests_failed++; $display("FAIL a_first_ar: got ar_valid %b busy %b, expected 1 1", m_ar_valid, m_busy);
    end
    collect(2000);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL a_timeout: got no finish, expected finish"); end
    tests_run++;
    if (ar_log_addr.size() != 8) begin
      tests_failed++; $display("FAIL a_bursts: got %0d, expected 8", ar_log_addr.size());
    end
    for (int i = 0; i < ar_log_addr.size(); i++) begin
      tests_run++;
      if (ar_log_addr[i] !== 32'h1000 + 32'(i) * 64 || ar_log_len[i] !== 8'd15) begin
        tests_failed++; $display("FAIL a_ar%0d: got %h/%0d, expected %h/15", i, ar_log_addr[i],
          ar_log_len[i], 32'h1000 + 32'(i) * 64);
      end
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL a_nwr: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL a_wr: got %h, expected %h", g, e); end
    end
    tests_run++;
    if (lat_err != 0) begin tests_failed++; $display("FAIL a_latency: got %0d, expected 0", lat_err); end
    tests_run++;
    if (fin_cnt != 1 || fin_cyc != last_wr_cyc + 1 || busy_after !== 1'b0) begin
      tests_failed++; $display("FAIL a_finish: got cnt %0d at %0d busy %b, expected 1 at %0d busy 0",
        fin_cnt, fin_cyc, busy_after, last_wr_cyc + 1);
    end
  endtask

  task automatic test_load_b_gaps();
    logic [SBW-1:0] e, g;
    prep(5, 1'b1);
    base_b_drv = 32'h2000_0000;
    push_exp(3'b100, 32'h2000_0000, 256);
    send_req(3'b100);
    collect(4000);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL b_timeout: got no finish, expected finish"); end
    tests_run++;
    if (ar_unstable != 0) begin tests_failed++; $display("FAIL b_ar_stable: got %0d changes, expected 0", ar_unstable); end
    tests_run++;
    if (ar_log_addr.size() != 16) begin
      tests_failed++; $display("FAIL b_bursts: got %0d, expected 16", ar_log_addr.size());
    end
    for (int i = 0; i < ar_log_addr.size(); i++) begin
      tests_run++;
      if (ar_log_addr[i] !== 32'h2000_0000 + 32'(i) * 64 || ar_log_len[i] !== 8'd15) begin
        tests_failed++; $display("FAIL b_ar%0d: got %h/%0d, expected %h/15", i, ar_log_addr[i],
          ar_log_len[i], 32'h2000_0000 + 32'(i) * 64);
      end
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL b_nwr: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL b_wr: got %h, expected %h", g, e); end
    end
    tests_run++;
    if (lat_err != 0) begin tests_failed++; $display("FAIL b_latency: got %0d, expected 0", lat_err); end
    tests_run++;
    if (fin_cnt != 1 || fin_cyc != last_wr_cyc + 1) begin
      tests_failed++; $display("FAIL b_finish: got cnt %0d at %0d, expected 1 at %0d", fin_cnt, fin_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_c_short();
    logic [SBW-1:0] e, g;
    prep(0, 1'b0);
    tgt = 1'b1;
    base_c_drv = 32'h0;
    push_exp(3'b001, 32'h0, 20);
    send_req(3'b001);
    collect(500);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL c_timeout: got no finish, expected finish"); end
    tests_run++;
    if (ar_log_addr.size() != 2) begin
      tests_failed++; $display("FAIL c_bursts: got %0d, expected 2", ar_log_addr.size());
    end else begin
      tests_run++;
      if (ar_log_addr[0] !== 32'h0 || ar_log_len[0] !== 8'd15 || ar_log_addr[1] !== 32'h40 || ar_log_len[1] !== 8'd3) begin
        tests_failed++; $display("FAIL c_ar: got %h/%0d %h/%0d, expected 0/15 40/3",
          ar_log_addr[0], ar_log_len[0], ar_log_addr[1], ar_log_len[1]);
      end
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL c_nwr: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL c_wr: got %h, expected %h", g, e); end
    end
    tests_run++;
    if (fin_cnt != 1 || fin_cyc != last_wr_cyc + 1 || lat_err != 0) begin
      tests_failed++; $display("FAIL c_finish: got cnt %0d at %0d lat %0d, expected 1 at %0d lat 0",
        fin_cnt, fin_cyc, lat_err, last_wr_cyc + 1);
    end
    tgt = 1'b0;
  endtask

  task automatic test_errors();
    logic [SBW-1:0] e, g;
    int late_clear;
    prep(0, 1'b0);
    inj_resp_beat = 5; inj_last_beat = 10;
    base_a_drv = 32'h1000;
    push_exp(3'b010, 32'h1000, 128);
    send_req(3'b010);
    collect(2000);
    tests_run++;
    if (timed_out || fin_cnt != 1) begin
      tests_failed++; $display("FAIL err_finish: got timeout %b cnt %0d, expected 0 1", timed_out, fin_cnt);
    end
    tests_run++;
    if (got_q.size() != 128) begin tests_failed++; $display("FAIL err_nwr: got %0d, expected 128", got_q.size()); end
    if (err_at_wr.size() >= 6) begin
      tests_run++;
      if (err_at_wr[4] !== 1'b0 || err_at_wr[5] !== 1'b1) begin
        tests_failed++; $display("FAIL err_rise: got %b%b at words 4/5, expected 01", err_at_wr[4], err_at_wr[5]);
      end
      late_clear = 0;
      for (int i = 5; i < err_at_wr.size(); i++) if (err_at_wr[i] !== 1'b1) late_clear++;
      tests_run++;
      if (late_clear != 0) begin tests_failed++; $display("FAIL err_sticky: got %0d low samples, expected 0", late_clear); end
    end
    tests_run++;
    if (err_at_fin !== 1'b1 || err_after !== 1'b1) begin
      tests_failed++; $display("FAIL err_hold: got %b %b, expected 1 1", err_at_fin, err_after);
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL err_wr: got %h, expected %h", g, e); end
    end
    inj_resp_beat = -1; inj_last_beat = -1;
  endtask

  task automatic test_fresh_a();
    logic [SBW-1:0] e, g;
    prep(0, 1'b0);
    base_a_drv = 32'h0000_8000;
    push_exp(3'b010, 32'h0000_8000, 128);
    send_req(3'b010);
    tests_run++;
    if (m_err !== 1'b0 || m_ar_valid !== 1'b1) begin
      tests_failed++; $display("FAIL fresh_start: got err %b ar_valid %b, expected 0 1", m_err, m_ar_valid);
    end
    // a request while busy must be dropped
    req_sel_drv = 3'b100; req_valid_drv = 1'b1;
    @(negedge clk); #1;
    req_valid_drv = 1'b0;
    collect(2000);
    tests_run++;
    if (timed_out || fin_cnt != 1 || busy_after !== 1'b0) begin
      tests_failed++; $display("FAIL fresh_finish: got timeout %b cnt %0d busy %b, expected 0 1 0",
        timed_out, fin_cnt, busy_after);
    end
    tests_run++;
    if (ar_log_addr.size() != 8 || (ar_log_addr.size() != 0 && ar_log_addr[0] !== 32'h8000)) begin
      tests_failed++; $display("FAIL fresh_bursts: got %0d bursts, expected 8 from 8000", ar_log_addr.size());
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL fresh_nwr: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL fresh_wr: got %h, expected %h", g, e); end
    end
  endtask

  task automatic test_invalid_sel();
    prep(0, 1'b0);
    send_req(3'b011);
    tests_run++;
    if (m_finish !== 1'b1 || m_err !== 1'b1 || m_ar_valid !== 1'b0 || m_buf_we !== 3'b0) begin
      tests_failed++; $display("FAIL inv_done: got fin %b err %b ar %b we %b, expected 1 1 0 000",
        m_finish, m_err, m_ar_valid, m_buf_we);
    end
    @(negedge clk); #1;
    tests_run++;
    if (m_finish !== 1'b0 || m_busy !== 1'b0 || m_buf_we !== 3'b0 || ar_log_addr.size() != 0) begin
      tests_failed++; $display("FAIL inv_after: got fin %b busy %b we %b ars %0d, expected 0 0 000 0",
        m_finish, m_busy, m_buf_we, ar_log_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    prep(0, 1'b0);
    base_b_drv = 32'h2000_0000;
    send_req(3'b100);
    cyc = 0;
    while (global_beat < 41 && cyc < 1000) begin @(negedge clk); #1; cyc++; end
    tests_run++;
    if (global_beat < 41) begin tests_failed++; $display("FAIL rm_reach: got %0d beats, expected 41", global_beat); end
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if ({bus.busy, bus.finish, bus.err, bus.ar_valid, bus.r_ready, bus.buf_we} !== 8'b0 ||
        bus.ar_addr !== 32'h0 || bus.ar_len !== 8'h0 || bus.buf_addr !== 8'h0 ||
        bus.buf_wdata !== 32'h0 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL rm_outputs: got flags %b state %0d addr %h wdata %h, expected all 0",
        {bus.busy, bus.finish, bus.err, bus.ar_valid, bus.r_ready, bus.buf_we}, dbg_state,
        bus.buf_addr, bus.buf_wdata);
    end
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_a();
    test_load_b_gaps();
    test_c_short();
    test_errors();
    test_fresh_a();
    test_invalid_sel();
    test_reset_mid();
    test_fresh_a();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/tile_loader.md
Name: tile_loader

Overview:
- Services operand-load requests from the tensorcore control FSM.
- On a one-cycle request with a one-hot operand select (C, A or B), it fetches the operand tile from memory over an AXI4-style read channel using fixed-length bursts.
- Each returned word is written into the matching on-chip operand SRAM. A one-cycle finish pulse is returned when the last word has been written.

Parameters:
- WIDTH, 32, data word width in bits (one word per R beat).
- ADDR_W, 32, byte-address width.
- BURST_LEN, 16, maximum beats per AR burst.
- A_WORDS, 128, words in A tile (8x16).
- B_WORDS, 256, words in B tile (16x16).
- C_WORDS, 128, words in C tile.
- BUF_AW, 8, SRAM word-address width; must satisfy 2^BUF_AW >= max(A_WORDS, B_WORDS, C_WORDS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- req_valid  in  1  one-cycle load request.
- req_sel  in  3  operand select: 001=C, 010=A, 100=B.
- base_a, base_b, base_c  in  ADDR_W each  byte base address of each tile.
- busy  out  1  high from the cycle after an accepted request until finish.
- finish  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared only by reset or by the next accepted request.
- ar_valid  out  1  read-address valid.
- ar_ready  in  1  read-address ready.
- ar_addr  out  ADDR_W  burst start byte address.
- ar_len  out  8  beats minus one.
- r_valid  in  1  read-data valid.
- r_ready  out  1  read-data ready.
- r_data  in  WIDTH  read data.
- r_last  in  1  last beat of burst.
- r_resp  in  2  response; nonzero means error.
- buf_we  out  3  one-hot SRAM write enable, same encoding as req_sel.
- buf_addr  out  BUF_AW  SRAM word address.
- buf_wdata  out  WIDTH  SRAM write data.

Behaviour:
- Reset: while rst=0 at a clock edge, FSM goes to IDLE. All outputs are driven 0: busy, finish, err, ar_valid, ar_addr, ar_len, r_ready, buf_we, buf_addr, buf_wdata.
- Reset mid-transfer abandons the transfer. Outstanding beats are not drained; r_ready=0 holds them off.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On req_valid=1, latch sel, total = words(sel), addr = base(sel), word_cnt=0, clear err; go to ADDR.
  - Invalid sel (zero or multi-hot): set err, go directly to DONE. No AXI traffic, no writes.
- ADDR:
  - ar_valid=1, ar_addr=addr, ar_len = min(total-word_cnt, BURST_LEN)-1.
  - ar_valid, ar_addr and ar_len stay stable until the cycle where ar_valid && ar_ready; then go to DATA with beat_cnt=0.
  - First ar_valid appears the cycle after req_valid.
- DATA:
  - r_ready=1. Each cycle with r_valid && r_ready is a beat.
  - On the next cycle after a beat: buf_we=sel, buf_addr=word_cnt (pre-increment), buf_wdata=r_data. Registered write, latency exactly 1.
  - Per beat: word_cnt+1, beat_cnt+1.
  - On the final beat of the burst (beat_cnt == ar_len): addr += (ar_len+1)*(WIDTH/8), modulo 2^ADDR_W.
  - After the final beat of the burst: if word_cnt+1 < total go to ADDR, else go to DONE.
  - Beats are counted by beat_cnt, not by r_last.
- Error detection in DATA:
  - r_last must equal (beat_cnt == ar_len); any mismatch sets err.
  - r_resp != 0 sets err.
  - Transfer continues unchanged in both cases; data is still written.
- DONE: finish=1 for exactly one cycle, which is the cycle after the last buf_we (or the cycle after the request for an invalid sel); then IDLE.
- busy: high in ADDR, DATA, DONE.
- req_valid while not in IDLE is ignored. No queuing.
- buf_we is 0 in every cycle without a beat in the previous cycle.
- Width rules: word_cnt needs BUF_AW+1 bits so it can reach total. Tile sizes need not be multiples of BURST_LEN; the last burst is shortened.

Test Plan:
- Reset, then req_sel=010 (A), base_a=0x1000, zero-wait AXI. Expect:
  - 8 bursts at 0x1000, 0x1040 … 0x11C0, each ar_len=15.
  - 128 buf_we=010 writes, buf_addr 0..127 with data matching memory.
  - finish one cycle after the write to addr 127; busy low afterwards.
- req_sel=100 (B) with random r_valid gaps and ar_ready delayed 5 cycles. Expect:
  - ar_* held stable while waiting.
  - 256 writes in order, one cycle after each handshake; a single finish.
- Parameter override C_WORDS=20, req_sel=001, base_c=0x0. Expect:
  - Bursts at 0x0 with ar_len=15, then 0x40 with ar_len=3.
  - 20 writes, then finish.
- Inject r_resp=2 on beat 5 and r_last early on beat 10 of an A load. Expect:
  - err rises after the faulty beat and stays high.
  - All 128 writes still occur; finish asserted.
  - err clears on the next accepted request.
- req_sel=011. Expect err=1 and finish the cycle after the request, with no ar_valid and no buf_we. Also assert req_valid while busy: it is ignored.
- Assert rst=0 during beat 40 of a B load. Expect:
  - All outputs 0 the next cycle.
  - A fresh A request after reset completes normally.
